// File: rtl/stg_4_me_pkg.sv
// Shared constants for the memory/print stage: datapath widths and print FIFO defaults.
package stg_4_me_pkg;
  localparam int VALUE_W         = 32;
  localparam int REG_ADDR_W      = 5;
  localparam int PRINT_DEPTH_DEF = 8;
  localparam int OVF_W_DEF       = 8;
endpackage

// File: rtl/stg_4_me_print_fifo.sv
// Print queue storage: RAM, wrapping read/write pointers and occupancy counter.
// The caller gates push/pop, so this block never sees a push while full without a pop.
module print_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // NOTE: storage has no reset; occupancy alone decides which entries are live,
  // so clearing the RAM would only cost flops and reset fan-out.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Head read is combinational from the registered RAM, so a push shows up one cycle later.
  assign rdata = mem[rd_ptr];
endmodule

// File: rtl/stg_4_me.sv
// Memory/print stage: registers EX results for writeback and queues print requests
// into a small FIFO drained over a valid/ready port, counting dropped prints.
module stg_4_me
  import stg_4_me_pkg::*;
#(
  parameter int PRINT_DEPTH = PRINT_DEPTH_DEF,
  parameter int OVF_W       = OVF_W_DEF
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [REG_ADDR_W-1:0]        r_me_rd,
  input  logic [VALUE_W-1:0]           r_me_aluout,
  input  logic                         r_me_aluzero,
  input  logic                         r_me_RegWrite,
  input  logic                         r_me_PrintValue,
  input  logic                         print_ready,
  output logic [REG_ADDR_W-1:0]        r_wb_rd,
  output logic [VALUE_W-1:0]           r_wb_value,
  output logic                         r_wb_aluzero,
  output logic                         r_wb_RegWrite,
  output logic                         print_valid,
  output logic [VALUE_W-1:0]           print_data,
  output logic [$clog2(PRINT_DEPTH):0] print_count,
  output logic [OVF_W-1:0]             print_overflow
);
  localparam int CNT_W = $clog2(PRINT_DEPTH) + 1;

  logic full;
  logic push;
  logic pop;
  logic drop;

  assign print_valid = (print_count != '0);
  assign full        = (print_count == CNT_W'(PRINT_DEPTH));
  assign pop         = print_valid & print_ready;
  // A pop frees the slot this cycle, so a full FIFO can still accept a push.
  assign push        = r_me_PrintValue & (~full | pop);
  assign drop        = r_me_PrintValue & full & ~pop;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wb_rd       <= '0;
      r_wb_value    <= '0;
      r_wb_aluzero  <= 1'b0;
      r_wb_RegWrite <= 1'b0;
    end else begin
      r_wb_rd       <= r_me_rd;
      r_wb_value    <= r_me_aluout;
      r_wb_aluzero  <= r_me_aluzero;
      r_wb_RegWrite <= r_me_RegWrite;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      print_overflow <= '0;
    end else if (drop && (print_overflow != {OVF_W{1'b1}})) begin
      print_overflow <= print_overflow + 1'b1;
    end
  end

  print_fifo #(
    .W     (VALUE_W),
    .DEPTH (PRINT_DEPTH)
  ) u_print_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .wdata (r_me_aluout),
    .pop   (pop),
    .rdata (print_data),
    .count (print_count)
  );
endmodule
